// File: rtl/overlay_panel_pkg.sv
// Shared types for the overlay_panel slice: VGA bus layout and a span-test helper.
// Bus packing, MSB first: hcount, hsync, hblnk, vcount, vsync, vblnk, rgb.
package overlay_panel_pkg;

    localparam int unsigned VGA_BUS_SIZE = 38;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    // Half-open interval test [lo, hi) on 12-bit coordinates, so sums never wrap.
    function automatic logic in_span(input logic [11:0] pos, input logic [11:0] lo,
                                     input logic [11:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/overlay_panel_if.sv
// VGA bus bundle; the producer drives through master, the consumer reads through slave.
interface overlay_panel_if;
    import overlay_panel_pkg::*;

    vga_bus_t bus;

    modport master (output bus);
    modport slave  (input  bus);

endinterface

// File: rtl/overlay_panel_vsync_edge_tick.sv
// One-cycle frame tick on the rising edge of vsync; reusable by animated overlays.
module vsync_edge_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync_in;
        end
    end

    assign tick = vsync_in & ~vsync_d;

endmodule

// File: rtl/overlay_panel.sv
// Solid rectangle overlay with frame-synchronous slide-in and optional blinking.
// The VGA bus is registered once; only rgb is replaced inside the drawn rectangle.
module overlay_panel
    import overlay_panel_pkg::*;
#(
    parameter int unsigned XPOS         = 100,
    parameter int unsigned YPOS         = 100,
    parameter int unsigned WIDTH        = 50,
    parameter int unsigned HEIGHT       = 50,
    parameter logic [11:0] COLOR        = 12'h000,
    parameter int unsigned SLIDE_DIST   = 200,
    parameter int unsigned SLIDE_STEP   = 8,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            module_en,
    overlay_panel_if.slave  vga_bus_in,
    overlay_panel_if.master vga_bus_out,
    output logic            anim_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLIDE = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [11:0] X_LO       = 12'(XPOS);
    localparam logic [11:0] X_HI       = 12'(XPOS + WIDTH);
    localparam logic [11:0] Y_LO       = 12'(YPOS);
    localparam logic [11:0] Y_LEN      = 12'(HEIGHT);
    localparam logic [10:0] DIST       = 11'(SLIDE_DIST);
    localparam logic [10:0] STEP       = 11'(SLIDE_STEP);
    localparam logic [15:0] BLINK_LAST = (BLINK_FRAMES == 0) ? 16'd0 : 16'(BLINK_FRAMES - 1);

    state_t      state, state_nxt;
    logic [10:0] offset, offset_nxt;
    logic [15:0] blink_cnt, blink_cnt_nxt;
    logic        visible, visible_nxt;
    logic        tick;
    logic [11:0] y_top, y_bot;
    logic        draw;
    vga_bus_t    bus_nxt;

    vsync_edge_tick u_tick (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vga_bus_in.bus.vsync),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            offset    <= '0;
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else begin
            state     <= state_nxt;
            offset    <= offset_nxt;
            blink_cnt <= blink_cnt_nxt;
            visible   <= visible_nxt;
        end
    end

    // Disable is checked before any state-specific tick handling so abort wins.
    always_comb begin
        state_nxt     = state;
        offset_nxt    = offset;
        blink_cnt_nxt = blink_cnt;
        visible_nxt   = visible;
        if (!module_en) begin
            state_nxt     = ST_IDLE;
            offset_nxt    = '0;
            blink_cnt_nxt = '0;
            visible_nxt   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    blink_cnt_nxt = '0;
                    visible_nxt   = 1'b1;
                    if (DIST == '0) begin
                        state_nxt  = ST_SHOW;
                        offset_nxt = '0;
                    end else begin
                        state_nxt  = ST_SLIDE;
                        offset_nxt = DIST;
                    end
                end
                ST_SLIDE: begin
                    if (tick) begin
                        if (offset <= STEP) begin
                            offset_nxt = '0;
                            state_nxt  = ST_SHOW;
                        end else begin
                            offset_nxt = offset - STEP;
                        end
                    end
                end
                ST_SHOW: begin
                    if (BLINK_FRAMES == 0) begin
                        visible_nxt = 1'b1;
                    end else if (tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_nxt = '0;
                            visible_nxt   = ~visible;
                        end else begin
                            blink_cnt_nxt = blink_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign anim_done = (state == ST_SHOW);

    always_comb begin
        y_top = Y_LO + {1'b0, offset};
        y_bot = y_top + Y_LEN;
        draw  = (state != ST_IDLE) && visible
                && !vga_bus_in.bus.hblnk && !vga_bus_in.bus.vblnk
                && in_span({1'b0, vga_bus_in.bus.hcount}, X_LO, X_HI)
                && in_span({1'b0, vga_bus_in.bus.vcount}, y_top, y_bot);
        bus_nxt     = vga_bus_in.bus;
        bus_nxt.rgb = draw ? COLOR : vga_bus_in.bus.rgb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_bus_out.bus <= '0;
        end else begin
            vga_bus_out.bus <= bus_nxt;
        end
    end

endmodule
